readout_sequencer: RTL



---
 rtl/readout_sequencer.sv | 84 ++++++++
 1 files changed

// File: rtl/readout_sequencer.sv
// readout_sequencer: streams reservoir states against the W_out bank and emits one saturated readout sample per start.
module readout_sequencer #(
  parameter int N_NODES   = 50,
  parameter int ADDR_W    = 6,
  parameter int V_W       = 16,
  parameter int W_W       = 8,
  parameter int ACC_W     = 32,
  parameter int FRAC_BITS = 7
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  output logic                     busy,
  output logic [ADDR_W-1:0]        node_addr,
  input  logic signed [V_W-1:0]    V,
  input  logic                     wr_en,
  input  logic [ADDR_W-1:0]        wr_addr,
  input  logic signed [W_W-1:0]    wr_data,
  output logic                     wr_err,
  output logic signed [15:0]       y,
  output logic                     y_valid
);
  typedef enum logic [1:0] {IDLE, RUN, DRAIN, OUT} state_t;
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(N_NODES - 1);
  localparam logic signed [ACC_W-1:0] Y_MAX = ACC_W'(32767);
  localparam logic signed [ACC_W-1:0] Y_MIN = -ACC_W'(32768);
  state_t state;
  logic signed [W_W-1:0] w [N_NODES];
  logic signed [W_W-1:0] w_reg;
  logic signed [ACC_W-1:0] acc;
  logic signed [ACC_W-1:0] sh;
  logic signed [V_W+W_W-1:0] prod;
  logic signed [15:0] y_sat;
  logic wr_ok;
  always_comb begin
    wr_ok = state == IDLE && wr_addr <= LAST;
    prod  = V * w_reg;
    sh    = acc >>> FRAC_BITS;
    y_sat = sh > Y_MAX ? 16'sh7fff : sh < Y_MIN ? 16'sh8000 : sh[15:0];
  end
  // node_addr doubles as the run index so the address lines up with the weight captured at the same edge
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      busy      <= 1'b0;
      node_addr <= '0;
      wr_err    <= 1'b0;
      y         <= '0;
      y_valid   <= 1'b0;
      acc       <= '0;
      w_reg     <= '0;
      for (int i = 0; i < N_NODES; i++) w[i] <= '0;
    end else begin
      y_valid <= 1'b0;
      wr_err  <= wr_en && !wr_ok;
      if (wr_en && wr_ok) w[wr_addr] <= wr_data;
      case (state)
        IDLE: begin
          busy <= start && !y_valid;
          if (start && !y_valid) begin
            state     <= RUN;
            acc       <= '0;
            node_addr <= '0;
          end
        end
        RUN: begin
          w_reg <= w[node_addr];
          if (node_addr != '0) acc <= acc + ACC_W'(prod);
          if (node_addr == LAST) state <= DRAIN;
          else node_addr <= node_addr + 1'b1;
        end
        DRAIN: begin
          acc   <= acc + ACC_W'(prod);
          state <= OUT;
        end
        default: begin
          y       <= y_sat;
          y_valid <= 1'b1;
          state   <= IDLE;
        end
      endcase
    end
  end
endmodule
